// File: rtl/drive_mode_fsm.sv
// Drive-mode controller: arbitrates IR manual control against camera-driven search/track,
// with a manual watchdog, target-loss timeout and debounced camera direction.
module drive_mode_fsm #(
    parameter int                 IR_W           = 8,
    parameter int                 DIR_W          = 3,
    parameter int                 SPEED_W        = 2,
    parameter int                 HOLD_CYCLES    = 2_500_000,
    parameter int                 TIMEOUT_CYCLES = 50_000_000,
    parameter logic [IR_W-1:0]    IR_STOP        = 8'h00,
    parameter logic [IR_W-1:0]    IR_MANUAL      = 8'h01,
    parameter logic [IR_W-1:0]    IR_AUTO        = 8'h02,
    parameter logic [IR_W-1:0]    IR_DIR_BASE    = 8'h10,
    parameter logic [DIR_W-1:0]   DIR_SEARCH     = 3'd1,
    parameter logic [SPEED_W-1:0] SEARCH_SPEED   = 2'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ir_valid,
    input  logic [IR_W-1:0]    ir_code,
    input  logic               cam_seen,
    input  logic [DIR_W-1:0]   cam_dir,
    input  logic [SPEED_W-1:0] speed,
    output logic [1:0]         mode_state,
    output logic [DIR_W-1:0]   drive_cmd,
    output logic [SPEED_W-1:0] drive_speed,
    output logic               drive_valid,
    output logic               timeout_flag
);

    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam int OFW = IR_W + 1;

    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  T_DONE   = TW'(TIMEOUT_CYCLES);
    localparam logic [HW-1:0]  H_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  H_MAX    = HW'(HOLD_CYCLES);
    localparam logic [OFW-1:0] DIR_SPAN = OFW'(2 ** DIR_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SEARCH = 2'd2,
        S_TRACK  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [DIR_W-1:0]   cmd_nxt;
    logic [SPEED_W-1:0] speed_nxt;
    logic               valid_nxt, flag_nxt;
    logic [TW-1:0]      wd_cnt, wd_nxt, lost_cnt, lost_nxt;
    logic [HW-1:0]      seen_cnt, seen_nxt, hold_cnt, hold_nxt, run;
    logic [DIR_W-1:0]   cand_dir, cand_nxt;
    logic               enter;

    function automatic logic [TW-1:0] sat_inc_t(input logic [TW-1:0] v);
        return (v == T_DONE) ? v : v + TW'(1);
    endfunction

    function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
        return (v == H_MAX) ? v : v + HW'(1);
    endfunction

    logic [OFW-1:0]   ir_off;
    logic             ir_stop, ir_manual, ir_auto, ir_dir_hit;
    logic [DIR_W-1:0] ir_dir;

    assign ir_off     = {1'b0, ir_code} - {1'b0, IR_DIR_BASE};
    assign ir_stop    = ir_valid && (ir_code == IR_STOP);
    assign ir_manual  = ir_valid && (ir_code == IR_MANUAL) && !ir_stop;
    assign ir_auto    = ir_valid && (ir_code == IR_AUTO) && !ir_stop && !ir_manual;
    assign ir_dir_hit = ir_valid && !ir_stop && !ir_manual && !ir_auto
                        && (ir_code >= IR_DIR_BASE) && (ir_off < DIR_SPAN);
    assign ir_dir     = ir_off[DIR_W-1:0];

    assign mode_state = state;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = drive_cmd;
        flag_nxt  = 1'b0;
        wd_nxt    = wd_cnt;
        seen_nxt  = seen_cnt;
        lost_nxt  = lost_cnt;
        hold_nxt  = hold_cnt;
        cand_nxt  = cand_dir;
        run       = '0;
        enter     = 1'b0;

        case (state)
            S_IDLE: cmd_nxt = '0;
            S_MANUAL: begin
                // wd_cnt parks at T_DONE after firing so the pulse is not repeated
                if (ir_dir_hit) begin
                    cmd_nxt = ir_dir;
                    wd_nxt  = '0;
                end else if (wd_cnt == T_LAST) begin
                    cmd_nxt  = '0;
                    flag_nxt = 1'b1;
                    wd_nxt   = T_DONE;
                end else begin
                    wd_nxt = sat_inc_t(wd_cnt);
                end
            end
            S_SEARCH: begin
                cmd_nxt = DIR_SEARCH;
                if (cam_seen) begin
                    if (seen_cnt == H_LAST) begin
                        state_nxt = S_TRACK;
                        cmd_nxt   = cam_dir;
                        enter     = 1'b1;
                    end else begin
                        seen_nxt = sat_inc_h(seen_cnt);
                    end
                end else begin
                    seen_nxt = '0;
                end
            end
            S_TRACK: begin
                if (cam_seen) begin
                    // run = consecutive cycles cam_dir has equalled the candidate, this one included
                    lost_nxt = '0;
                    run      = (cam_dir == cand_dir) ? sat_inc_h(hold_cnt) : HW'(1);
                    cand_nxt = cam_dir;
                    hold_nxt = run;
                    if (run == H_MAX) cmd_nxt = cam_dir;
                end else begin
                    hold_nxt = '0;
                    if (lost_cnt == T_LAST) begin
                        state_nxt = S_SEARCH;
                        cmd_nxt   = DIR_SEARCH;
                        flag_nxt  = 1'b1;
                        enter     = 1'b1;
                    end else begin
                        lost_nxt = sat_inc_t(lost_cnt);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (ir_stop) begin
            state_nxt = S_IDLE;
            cmd_nxt   = '0;
            flag_nxt  = 1'b0;
            enter     = 1'b1;
        end else if (ir_manual) begin
            state_nxt = S_MANUAL;
            cmd_nxt   = '0;
            flag_nxt  = 1'b0;
            enter     = 1'b1;
        end else if (ir_auto) begin
            state_nxt = S_SEARCH;
            cmd_nxt   = DIR_SEARCH;
            flag_nxt  = 1'b0;
            enter     = 1'b1;
        end

        if (enter) begin
            wd_nxt   = '0;
            seen_nxt = '0;
            lost_nxt = '0;
            hold_nxt = '0;
            cand_nxt = cam_dir;
        end

        case (state_nxt)
            S_IDLE:   speed_nxt = '0;
            S_SEARCH: speed_nxt = SEARCH_SPEED;
            default:  speed_nxt = speed;
        endcase
        valid_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            drive_cmd    <= '0;
            drive_speed  <= '0;
            drive_valid  <= 1'b0;
            timeout_flag <= 1'b0;
            wd_cnt       <= '0;
            seen_cnt     <= '0;
            lost_cnt     <= '0;
            hold_cnt     <= '0;
            cand_dir     <= '0;
        end else begin
            state        <= state_nxt;
            drive_cmd    <= cmd_nxt;
            drive_speed  <= speed_nxt;
            drive_valid  <= valid_nxt;
            timeout_flag <= flag_nxt;
            wd_cnt       <= wd_nxt;
            seen_cnt     <= seen_nxt;
            lost_cnt     <= lost_nxt;
            hold_cnt     <= hold_nxt;
            cand_dir     <= cand_nxt;
        end
    end

endmodule

// File: tb/tb_drive_mode_fsm.sv
// Bench for drive_mode_fsm: directed scenarios plus randomized traffic checked against a
// run-length based behavioural model of the drive-mode rules.
module tb_drive_mode_fsm;

    localparam int HOLD = 4;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir_valid = 1'b0;
    logic [7:0] ir_code = '0;
    logic       cam_seen = 1'b0;
    logic [2:0] cam_dir = '0;
    logic [1:0] speed = '0;
    logic [1:0] mode_state;
    logic [2:0] drive_cmd;
    logic [1:0] drive_speed;
    logic       drive_valid;
    logic       timeout_flag;

    drive_mode_fsm #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir_valid    (ir_valid),
        .ir_code     (ir_code),
        .cam_seen    (cam_seen),
        .cam_dir     (cam_dir),
        .speed       (speed),
        .mode_state  (mode_state),
        .drive_cmd   (drive_cmd),
        .drive_speed (drive_speed),
        .drive_valid (drive_valid),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0..3 plus run lengths since the relevant event
    int m_mode, m_cmd, m_spd, m_vld, m_flag;
    int idle_run, seen_run, lost_run, dir_run, prev_dir;
    bit fired;

    function automatic void model_reset();
        m_mode = 0; m_cmd = 0; m_spd = 0; m_vld = 0; m_flag = 0;
        idle_run = 0; seen_run = 0; lost_run = 0; dir_run = 0; prev_dir = -1; fired = 0;
    endfunction

    function automatic void model_step();
        int  code    = int'(ir_code);
        int  nm      = m_mode;
        bit  ctrl    = 0;
        bit  entered = 0;
        m_flag = 0;
        if (ir_valid && code == 0)      begin nm = 0; m_cmd = 0; ctrl = 1; end
        else if (ir_valid && code == 1) begin nm = 1; m_cmd = 0; ctrl = 1; end
        else if (ir_valid && code == 2) begin nm = 2; m_cmd = 1; ctrl = 1; end
        if (ctrl) entered = 1;
        else begin
            case (m_mode)
                0: m_cmd = 0;
                1: begin
                    if (ir_valid && code >= 16 && code < 24) begin
                        m_cmd = code - 16; idle_run = 0; fired = 0;
                    end else begin
                        idle_run++;
                        if (idle_run >= TMO && !fired) begin fired = 1; m_cmd = 0; m_flag = 1; end
                    end
                end
                2: begin
                    m_cmd = 1;
                    if (cam_seen) begin
                        seen_run++;
                        if (seen_run >= HOLD) begin nm = 3; m_cmd = int'(cam_dir); entered = 1; end
                    end else seen_run = 0;
                end
                default: begin
                    if (cam_seen) begin
                        lost_run = 0;
                        if (int'(cam_dir) == prev_dir) dir_run++;
                        else begin dir_run = 1; prev_dir = int'(cam_dir); end
                        if (dir_run >= HOLD) m_cmd = int'(cam_dir);
                    end else begin
                        dir_run = 0;
                        lost_run++;
                        if (lost_run >= TMO) begin nm = 2; m_cmd = 1; m_flag = 1; entered = 1; end
                    end
                end
            endcase
        end
        if (entered) begin
            idle_run = 0; fired = 0; seen_run = 0; lost_run = 0; dir_run = 0; prev_dir = -1;
        end
        m_mode = nm;
        m_vld  = (nm != 0) ? 1 : 0;
        m_spd  = (nm == 0) ? 0 : (nm == 2) ? 1 : int'(speed);
    endfunction

    task automatic tick();
        if (rst_n) model_step(); else model_reset();
        @(posedge clk);
        #1;
        ir_valid = 1'b0;
    endtask

    task automatic send_ir(input logic [7:0] c);
        ir_valid = 1'b1;
        ir_code  = c;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; speed = 2'd2; cam_seen = 1'b1; cam_dir = 3'd4;
        repeat (3) tick();
        n_checks++; if (mode_state !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode_state); else n_pass++;
        n_checks++; if (drive_cmd !== 3'd0) $display("FAIL reset_cmd got %0d want 0", drive_cmd); else n_pass++;
        n_checks++; if (drive_speed !== 2'd0) $display("FAIL reset_speed got %0d want 0", drive_speed); else n_pass++;
        n_checks++; if (drive_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", drive_valid); else n_pass++;
        n_checks++; if (timeout_flag !== 1'b0) $display("FAIL reset_flag got %0b want 0", timeout_flag); else n_pass++;
        rst_n = 1'b1;
        repeat (5) tick();
        n_checks++; if (mode_state !== 2'd0 || drive_valid !== 1'b0 || drive_speed !== 2'd0)
            $display("FAIL idle_ignores_cam got mode %0d valid %0b spd %0d want 0 0 0", mode_state, drive_valid, drive_speed);
        else n_pass++;
    endtask

    task automatic test_manual();
        cam_seen = 1'b0; speed = 2'd2;
        send_ir(8'h01);
        n_checks++; if (mode_state !== 2'd1) $display("FAIL manual_mode got %0d want 1", mode_state); else n_pass++;
        n_checks++; if (drive_valid !== 1'b1) $display("FAIL manual_valid got %0b want 1", drive_valid); else n_pass++;
        n_checks++; if (drive_cmd !== 3'd0) $display("FAIL manual_cmd0 got %0d want 0", drive_cmd); else n_pass++;
        n_checks++; if (drive_speed !== 2'd2) $display("FAIL manual_speed got %0d want 2", drive_speed); else n_pass++;
        send_ir(8'h13);
        n_checks++; if (drive_cmd !== 3'd3) $display("FAIL manual_dir3 got %0d want 3", drive_cmd); else n_pass++;
    endtask

    task automatic test_watchdog();
        for (int i = 1; i <= TMO; i++) begin
            tick();
            n_checks++;
            if (timeout_flag !== (i == TMO) || drive_cmd !== ((i == TMO) ? 3'd0 : 3'd3))
                $display("FAIL watchdog clk %0d got flag %0b cmd %0d want flag %0b cmd %0d",
                         i, timeout_flag, drive_cmd, (i == TMO), (i == TMO) ? 0 : 3);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (timeout_flag !== 1'b0 || mode_state !== 2'd1)
                $display("FAIL watchdog_hold got flag %0b mode %0d want 0 1", timeout_flag, mode_state);
            else n_pass++;
        end
        send_ir(8'h16);
        repeat (TMO - 1) tick();
        send_ir(8'h12);
        n_checks++;
        if (drive_cmd !== 3'd2 || timeout_flag !== 1'b0)
            $display("FAIL watchdog_ir_override got cmd %0d flag %0b want 2 0", drive_cmd, timeout_flag);
        else n_pass++;
    endtask

    task automatic test_search_track();
        cam_seen = 1'b1; cam_dir = 3'd2; speed = 2'd3;
        send_ir(8'h02);
        n_checks++; if (mode_state !== 2'd2 || drive_cmd !== 3'd1 || drive_speed !== 2'd1)
            $display("FAIL search_entry got mode %0d cmd %0d spd %0d want 2 1 1", mode_state, drive_cmd, drive_speed);
        else n_pass++;
        repeat (3) tick();
        cam_seen = 1'b0;
        tick();
        n_checks++; if (mode_state !== 2'd2) $display("FAIL search_short_run got %0d want 2", mode_state); else n_pass++;
        cam_seen = 1'b1;
        for (int i = 1; i <= HOLD; i++) begin
            tick();
            n_checks++;
            if (mode_state !== ((i == HOLD) ? 2'd3 : 2'd2))
                $display("FAIL search_hold clk %0d got mode %0d want %0d", i, mode_state, (i == HOLD) ? 3 : 2);
            else n_pass++;
        end
        n_checks++; if (drive_cmd !== 3'd2 || drive_speed !== 2'd3)
            $display("FAIL track_entry got cmd %0d spd %0d want 2 3", drive_cmd, drive_speed);
        else n_pass++;
    endtask

    task automatic test_track_debounce();
        cam_dir = 3'd5; repeat (2) tick();
        cam_dir = 3'd2; repeat (2) tick();
        n_checks++; if (drive_cmd !== 3'd2) $display("FAIL track_glitch got %0d want 2", drive_cmd); else n_pass++;
        cam_dir = 3'd5;
        for (int i = 1; i <= HOLD; i++) begin
            tick();
            n_checks++;
            if (drive_cmd !== ((i == HOLD) ? 3'd5 : 3'd2))
                $display("FAIL track_debounce clk %0d got %0d want %0d", i, drive_cmd, (i == HOLD) ? 5 : 2);
            else n_pass++;
        end
    endtask

    task automatic test_target_loss();
        cam_seen = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            tick();
            n_checks++;
            if (mode_state !== ((i == TMO) ? 2'd2 : 2'd3) || timeout_flag !== (i == TMO)
                || drive_cmd !== ((i == TMO) ? 3'd1 : 3'd5))
                $display("FAIL target_loss clk %0d got mode %0d flag %0b cmd %0d", i, mode_state, timeout_flag, drive_cmd);
            else n_pass++;
        end
        tick();
        n_checks++; if (timeout_flag !== 1'b0) $display("FAIL loss_single_pulse got %0b want 0", timeout_flag); else n_pass++;
    endtask

    task automatic test_ir_priority();
        cam_seen = 1'b1; cam_dir = 3'd3;
        repeat (HOLD - 1) tick();
        send_ir(8'h00);
        n_checks++;
        if (mode_state !== 2'd0 || drive_cmd !== 3'd0 || drive_speed !== 2'd0 || drive_valid !== 1'b0 || timeout_flag !== 1'b0)
            $display("FAIL ir_stop_priority got mode %0d cmd %0d spd %0d vld %0b flag %0b want all 0",
                     mode_state, drive_cmd, drive_speed, drive_valid, timeout_flag);
        else n_pass++;
        send_ir(8'h55);
        send_ir(8'h14);
        n_checks++;
        if (mode_state !== 2'd0 || drive_cmd !== 3'd0)
            $display("FAIL idle_ignores_codes got mode %0d cmd %0d want 0 0", mode_state, drive_cmd);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        cam_seen = 1'b1; cam_dir = 3'd6; speed = 2'd2;
        send_ir(8'h02);
        repeat (HOLD) tick();
        n_checks++; if (mode_state !== 2'd3) $display("FAIL pre_reset_track got %0d want 3", mode_state); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mode_state !== 2'd0 || drive_cmd !== 3'd0 || drive_speed !== 2'd0 || drive_valid !== 1'b0 || timeout_flag !== 1'b0)
            $display("FAIL async_reset got mode %0d cmd %0d spd %0d vld %0b flag %0b want all 0",
                     mode_state, drive_cmd, drive_speed, drive_valid, timeout_flag);
        else n_pass++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int p_seen = 50;
        int r;
        logic prev_flag = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 150 == 0) begin
                r = $urandom_range(0, 2);
                p_seen = (r == 0) ? 10 : (r == 1) ? 60 : 95;
            end
            cam_seen = ($urandom_range(0, 99) < p_seen);
            if ($urandom_range(0, 9) == 0) cam_dir = 3'($urandom);
            if ($urandom_range(0, 19) == 0) speed = 2'($urandom);
            if ($urandom_range(0, 99) < 3) begin
                r = $urandom_range(0, 9);
                if (r == 0)      ir_code = 8'h00;
                else if (r <= 3) ir_code = 8'h01;
                else if (r <= 5) ir_code = 8'h02;
                else if (r <= 8) ir_code = 8'(8'h10 + $urandom_range(0, 7));
                else             ir_code = 8'(8'h18 + $urandom_range(0, 200));
                ir_valid = 1'b1;
            end
            tick();
            n_checks++; if (mode_state !== 2'(m_mode))
                $display("FAIL rand_mode cyc %0d got %0d want %0d", cyc, mode_state, m_mode); else n_pass++;
            n_checks++; if (drive_cmd !== 3'(m_cmd))
                $display("FAIL rand_cmd cyc %0d got %0d want %0d", cyc, drive_cmd, m_cmd); else n_pass++;
            n_checks++; if (drive_speed !== 2'(m_spd))
                $display("FAIL rand_speed cyc %0d got %0d want %0d", cyc, drive_speed, m_spd); else n_pass++;
            n_checks++; if (drive_valid !== 1'(m_vld))
                $display("FAIL rand_valid cyc %0d got %0b want %0d", cyc, drive_valid, m_vld); else n_pass++;
            n_checks++; if (timeout_flag !== 1'(m_flag))
                $display("FAIL rand_flag cyc %0d got %0b want %0d", cyc, timeout_flag, m_flag); else n_pass++;
            n_checks++; if (timeout_flag === 1'b1 && prev_flag === 1'b1)
                $display("FAIL flag_double cyc %0d got 2 consecutive pulses want at most 1", cyc); else n_pass++;
            prev_flag = timeout_flag;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_manual();
        test_watchdog();
        test_search_track();
        test_track_debounce();
        test_target_loss();
        test_ir_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
